// File: rtl/ioctl_upload_pkg.sv
// Shared types and helpers for the HPS upload read path.
package ioctl_upload_pkg;

  typedef enum logic {IDLE, WAIT} upl_state_t;

  localparam int unsigned LINE_BYTES     = 8;
  localparam int unsigned WORDS_PER_LINE = 4;

  // Picks 16-bit word k from a 64-bit line, optionally byte-swapped to mirror the download order.
  function automatic logic [15:0] word_sel(input logic [63:0] line, input logic [1:0] k, input logic swap);
    logic [15:0] w;
    w = line[{k, 4'b0000} +: 16];
    return swap ? {w[7:0], w[15:8]} : w;
  endfunction

endpackage

// File: rtl/upload_line_buf.sv
// One-line read buffer: 64-bit data, line tag and valid bit with hit compare and word select.
module upload_line_buf
  import ioctl_upload_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned SWAP_BYTES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:3] tag_in,
  input  logic [63:0]       line_in,
  input  logic [ADDR_W-1:3] lookup_tag,
  input  logic [1:0]        k,
  output logic              hit,
  output logic [15:0]       word
);

  logic [63:0]       data;
  logic [ADDR_W-1:3] tag;
  logic              valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      tag   <= '0;
      valid <= 1'b0;
    end else begin
      if (load) begin
        data <= line_in;
        tag  <= tag_in;
      end
      // A clear in the same cycle as a fill leaves the line invalid.
      if (clear)
        valid <= 1'b0;
      else if (load)
        valid <= 1'b1;
    end
  end

  assign hit  = valid && (tag == lookup_tag);
  assign word = word_sel(data, k, SWAP_BYTES != 0);

endmodule

// File: rtl/ioctl_upload_reader.sv
// Services HPS upload reads from a one-line buffer, fetching 64-bit lines over the toggle req/ack port.
module ioctl_upload_reader
  import ioctl_upload_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned SWAP_BYTES = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [15:0]       ioctl_din,
  output logic              ioctl_wait,
  input  logic              inval,
  output logic [ADDR_W-1:0] mem_rdaddr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [63:0]       mem_dout
);

  upl_state_t        state_q, state_d;
  logic              upload_q;
  logic [1:0]        k_q, k_d;
  logic [15:0]       din_d;
  logic              wait_d;
  logic [ADDR_W-1:0] rdaddr_d;
  logic              req_d;
  logic              upload_rise;
  logic              ack_seen;
  logic              buf_hit;
  logic [15:0]       buf_word;
  logic              unused_addr0;

  assign unused_addr0 = ioctl_addr[0];
  assign upload_rise  = ioctl_upload && !upload_q;
  assign ack_seen     = (state_q == WAIT) && (mem_rd_req == mem_rd_ack);

  upload_line_buf #(
    .ADDR_W     (ADDR_W),
    .SWAP_BYTES (SWAP_BYTES)
  ) u_line_buf (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .load       (ack_seen),
    .clear      (inval || upload_rise),
    .tag_in     (mem_rdaddr[ADDR_W-1:3]),
    .line_in    (mem_dout),
    .lookup_tag (ioctl_addr[ADDR_W-1:3]),
    .k          (ioctl_addr[2:1]),
    .hit        (buf_hit),
    .word       (buf_word)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    din_d    = ioctl_din;
    wait_d   = ioctl_wait;
    rdaddr_d = mem_rdaddr;
    req_d    = mem_rd_req;
    case (state_q)
      IDLE: begin
        // Resync first so a miss in the same cycle toggles relative to the realigned level.
        if (upload_rise)
          req_d = mem_rd_ack;
        if (ioctl_rd) begin
          if (buf_hit && !inval && !upload_rise) begin
            din_d = buf_word;
          end else begin
            wait_d   = 1'b1;
            rdaddr_d = {ioctl_addr[ADDR_W-1:3], 3'b000};
            req_d    = ~req_d;
            k_d      = ioctl_addr[2:1];
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rd_req == mem_rd_ack) begin
          din_d   = word_sel(mem_dout, k_q, SWAP_BYTES != 0);
          wait_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      upload_q   <= 1'b0;
      k_q        <= '0;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      mem_rdaddr <= '0;
      mem_rd_req <= 1'b0;
    end else begin
      state_q    <= state_d;
      upload_q   <= ioctl_upload;
      k_q        <= k_d;
      ioctl_din  <= din_d;
      ioctl_wait <= wait_d;
      mem_rdaddr <= rdaddr_d;
      mem_rd_req <= req_d;
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Randomized bench for ioctl_upload_reader against a line-cache reference model and a delayed toggle responder.
module tb_ioctl_upload_reader;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned TAG_W  = ADDR_W - 3;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [15:0]       ioctl_din;
  logic              ioctl_wait;
  logic              inval;
  logic [ADDR_W-1:0] mem_rdaddr;
  logic              mem_rd_req;
  logic              mem_rd_ack;
  logic [63:0]       mem_dout;

  ioctl_upload_reader #(
    .ADDR_W     (ADDR_W),
    .SWAP_BYTES (1)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .inval        (inval),
    .mem_rdaddr   (mem_rdaddr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_ack   (mem_rd_ack),
    .mem_dout     (mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: what the one-line buffer should hold.
  bit               m_valid = 1'b0;
  logic [TAG_W-1:0] m_tag   = '0;
  int unsigned      gen     = 0;

  // Responder and observation state.
  bit          resp_en    = 1'b1;
  bit          busy       = 1'b0;
  int unsigned cnt        = 0;
  int unsigned resp_delay = 5;
  int unsigned toggles    = 0;
  logic        req_prev   = 1'b0;
  bit          upl_prev   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents; gen advances whenever the "core" writes memory.
  function automatic logic [63:0] mem_line(input logic [TAG_W-1:0] t, input int unsigned g);
    if (t == '0 && g == 0) return 64'h8877665544332211;
    return (64'h9E3779B97F4A7C15 * ({42'd0, t} + 64'd1)) ^ ({32'd0, g} << 24);
  endfunction

  function automatic logic [15:0] exp_word(input logic [63:0] line, input logic [1:0] k);
    logic [63:0] s;
    logic [15:0] w;
    s = line >> {k, 4'b0000};
    w = s[15:0];
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [ADDR_W-1:0] pick_addr();
    logic [TAG_W-1:0] t;
    case ($urandom_range(0, 4))
      0:       t = '0;
      1:       t = 22'd1;
      2:       t = 22'd2;
      3:       t = 22'd3;
      default: t = '1;
    endcase
    return {t, 2'($urandom), 1'($urandom)};
  endfunction

  // One clock: sample #1 after the edge, track toggles/upload edges, run the responder.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (mem_rd_req !== req_prev) toggles++;
    req_prev = mem_rd_req;
    if (ioctl_upload && !upl_prev) m_valid = 1'b0;
    upl_prev = ioctl_upload;
    if (resp_en) begin
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mem_dout   = mem_line(mem_rdaddr[ADDR_W-1:3], gen);
          mem_rd_ack = mem_rd_req;
          busy       = 1'b0;
        end
      end else if (mem_rd_req != mem_rd_ack) begin
        busy = 1'b1;
        cnt  = resp_delay;
      end
    end
  endtask

  task automatic do_inval();
    gen++;
    inval = 1'b1;
    tick();
    inval   = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input bit rd_in_wait,
                         input bit drop_upl, input bit inval_at_ack);
    logic [TAG_W-1:0] t;
    logic [15:0]      exp;
    bit               exp_hit;
    bit               coinc;
    int unsigned      cycles;
    t       = addr[ADDR_W-1:3];
    exp     = exp_word(mem_line(t, gen), addr[2:1]);
    exp_hit = m_valid && (m_tag == t);
    coinc   = 1'b0;
    toggles = 0;
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    if (exp_hit) begin
      check_eq("hit_din", 64'(ioctl_din), 64'(exp));
      check_eq("hit_wait", 64'(ioctl_wait), 64'd0);
      check_eq("hit_no_req", 64'(toggles), 64'd0);
    end else begin
      check_eq("miss_wait", 64'(ioctl_wait), 64'd1);
      check_eq("miss_addr", 64'(mem_rdaddr), 64'({t, 3'b000}));
      cycles = 1;
      while (ioctl_wait && cycles < 200) begin
        if (rd_in_wait && cycles == 1) begin
          ioctl_rd   = 1'b1;
          ioctl_addr = pick_addr();
        end
        if (drop_upl && cycles == 2) ioctl_upload = 1'b0;
        if (inval_at_ack && mem_rd_ack == mem_rd_req) begin
          inval = 1'b1;
          coinc = 1'b1;
        end
        tick();
        ioctl_rd = 1'b0;
        inval    = 1'b0;
        cycles++;
      end
      check_eq("miss_done", 64'(ioctl_wait), 64'd0);
      check_eq("miss_din", 64'(ioctl_din), 64'(exp));
      check_eq("miss_toggles", 64'(toggles), 64'd1);
      check_eq("wait_cycles", 64'(cycles - 1), 64'(resp_delay + 1));
      check_eq("addr_stable", 64'(mem_rdaddr), 64'({t, 3'b000}));
      m_valid = !coinc;
      m_tag   = t;
    end
  endtask

  task automatic apply_reset_checks(input string tag);
    check_eq({tag, "_din"}, 64'(ioctl_din), 64'd0);
    check_eq({tag, "_wait"}, 64'(ioctl_wait), 64'd0);
    check_eq({tag, "_rdaddr"}, 64'(mem_rdaddr), 64'd0);
    check_eq({tag, "_req"}, 64'(mem_rd_req), 64'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    inval        = 1'b0;
    mem_rd_ack   = 1'b0;
    mem_dout     = '0;
    #12;
    apply_reset_checks("reset");
    @(negedge clk_sys);
    reset_n = 1'b1;
    ioctl_upload = 1'b1;
    tick();
    tick();

    // Directed: cold read, line hits, next-line miss.
    resp_delay = 5;
    do_read(25'h000000, 0, 0, 0);
    check_eq("cold_din", 64'(ioctl_din), 64'h1122);
    do_read(25'h000002, 0, 0, 0);
    check_eq("w1_din", 64'(ioctl_din), 64'h3344);
    do_read(25'h000004, 0, 0, 0);
    check_eq("w2_din", 64'(ioctl_din), 64'h5566);
    do_read(25'h000006, 0, 0, 0);
    check_eq("w3_din", 64'(ioctl_din), 64'h7788);
    do_read(25'h000008, 0, 0, 0);
    do_read(25'h00000A, 0, 0, 0);
    do_inval();
    do_read(25'h00000A, 0, 0, 0);
    // inval coincident with ack, then same line must miss.
    do_read(25'h000010, 0, 0, 1);
    do_read(25'h000012, 0, 0, 0);
    // Read strobe during WAIT, upload drop during WAIT.
    do_read(25'h000018, 1, 0, 0);
    do_read(25'h000020, 0, 1, 0);
    tick();
    ioctl_upload = 1'b1;
    tick();
    do_read(25'h000022, 0, 0, 0);
    // Top line behaves like any other.
    do_read(25'h1FFFFFE, 0, 0, 0);
    do_read(25'h1FFFFF8, 0, 0, 0);
    do_read(25'h000000, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      resp_delay = $urandom_range(1, 6);
      if (sel < 10) begin
        do_inval();
      end else if (sel < 15) begin
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();
      end else begin
        bit drop;
        drop = ($urandom_range(0, 9) == 0);
        do_read(pick_addr(), $urandom_range(0, 4) == 0, drop, $urandom_range(0, 9) == 0);
        if (drop) begin
          ioctl_upload = 1'b1;
          tick();
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of WAIT, then resync on the next session.
    resp_delay = 8;
    ioctl_addr = 25'h000028;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    check_eq("pre_rst_wait", 64'(ioctl_wait), 64'd1);
    resp_en = 1'b0;
    busy    = 1'b0;
    #2;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    #1;
    apply_reset_checks("async_rst");
    mem_rd_ack = 1'b1;
    @(negedge clk_sys);
    reset_n  = 1'b1;
    upl_prev = 1'b0;
    m_valid  = 1'b0;
    tick();
    req_prev = mem_rd_req;
    ioctl_upload = 1'b1;
    tick();
    check_eq("resync_req", 64'(mem_rd_req), 64'd1);
    resp_en = 1'b1;
    do_read(25'h000028, 0, 0, 0);
    do_read(25'h00002C, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ioctl_upload_reader.md
# ioctl_upload_reader

Read-side counterpart of the ROM/SRAM download path: services HPS upload (ioctl read) requests by fetching 64-bit lines from the DDRAM responder over the toggle req/ack read protocol. It returns 16-bit words to `hps_io` with `ioctl_wait` flow control. A one-line buffer serves the remaining words of a line without extra memory traffic. It sits in `emu` between `hps_io` (upload port) and the DDRAM read port used for save-RAM dumps.

## Interface
Parameters:
- `ADDR_W`, 25: ioctl byte-address width.
- `SWAP_BYTES`, 1: 1 = output `{w[7:0],w[15:8]}` (mirror of download byte order); 0 = output unchanged.

Ports:
- `clk_sys` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `ioctl_upload` in 1: upload session active.
- `ioctl_rd` in 1: one-cycle read strobe for word at `ioctl_addr`.
- `ioctl_addr` in ADDR_W: byte address; bit 0 ignored.
- `ioctl_din` out 16: read data to HPS.
- `ioctl_wait` out 1: high while a fetch is outstanding.
- `inval` in 1: one-cycle pulse, invalidates line buffer (core wrote memory).
- `mem_rdaddr` out ADDR_W: line byte address, bits [2:0] always 0.
- `mem_rd_req` out 1: toggle request.
- `mem_rd_ack` in 1: toggle acknowledge, same clock domain.
- `mem_dout` in 64: line data, valid when `mem_rd_ack` == `mem_rd_req`.

## Operation
- States: IDLE, WAIT.
- Line buffer: 64-bit data, tag = addr[ADDR_W-1:3], valid bit.
- Word select: k = addr[2:1]; word = line[16k+15:16k]. Apply SWAP_BYTES.
- IDLE, `ioctl_rd` = 1:
  - Hit (valid, tag match, no `inval`, no `ioctl_upload` rising edge this cycle): `ioctl_din` ← selected buffered word. `ioctl_wait` stays 0.
  - Miss: `ioctl_wait` ← 1, `mem_rdaddr` ← {addr[ADDR_W-1:3],3'b000}, `mem_rd_req` toggles, latch k, go to WAIT.
- WAIT, `mem_rd_req` == `mem_rd_ack`:
  - Buffer ← `mem_dout`, tag ← request tag, valid ← 1.
  - `ioctl_din` ← word k of `mem_dout`, `ioctl_wait` ← 0, go to IDLE.
- `ioctl_rd` in WAIT is ignored: no second request, no state change.
- `ioctl_upload` rising edge: valid ← 0. In IDLE, `mem_rd_req` ← `mem_rd_ack` (resync).
- `ioctl_upload` falling in WAIT: the outstanding toggle cannot be cancelled. Complete normally, then IDLE.
- `inval` while idle: valid ← 0.
- `inval` in the ack cycle: data still delivered to `ioctl_din`, but valid ends 0 (`inval` wins).
- Tag wrap: the top line (all-ones tag) behaves like any other line. No address increment is performed internally.

## Timing
- Reset values: `ioctl_din`=0, `ioctl_wait`=0, `mem_rdaddr`=0, `mem_rd_req`=0, state IDLE, valid=0.
- Hit latency: `ioctl_din` is valid on the edge after the `ioctl_rd` cycle. `ioctl_wait` is never asserted.
- Miss: `ioctl_wait` and the `mem_rd_req` toggle are registered on the edge after `ioctl_rd`.
  - If ack equality is first seen in cycle N, `ioctl_din` is valid and `ioctl_wait` = 0 after edge N.
- `mem_rdaddr` is stable from the request toggle until ack.
- At most one request is outstanding.
- `reset_n` low mid-WAIT: immediate return to reset values. On the first `ioctl_upload` rising edge after reset, the resync rule realigns req/ack.

## Structure
- Package `ioctl_upload_pkg`:
  - state enum `upl_state_t` {IDLE, WAIT}.
  - `LINE_BYTES` = 8, `WORDS_PER_LINE` = 4.
  - function `word_sel(line, k, swap)`.
- One sub-module, `upload_line_buf`: holds data/tag/valid, with hit compare and word select. The FSM and handshake stay in the top module.

## Test plan
- Cold read, addr 0x000000; memory line 0x8877665544332211 acked 5 cycles later → wait high for 6 cycles; `ioctl_din` = 0x1122 (swap on); `mem_rdaddr` = 0.
- Follow-up reads at 0x2, 0x4, 0x6 → hits, no `mem_rd_req` toggle, outputs 0x3344, 0x5566, 0x7788 one cycle after each strobe.
- Read 0x8 after line 0 → miss, `mem_rdaddr` = 0x8, exactly one toggle.
- `inval` pulsed, then read 0x2 → miss. `inval` coincident with ack → data delivered, next read of the same line misses.
- `ioctl_rd` pulsed during WAIT → ignored, single toggle, wait unaffected. `ioctl_upload` dropped in WAIT → completes at ack, returns to IDLE.
- `reset_n` low during WAIT → all outputs 0 asynchronously. New upload session → req resynced to ack; first read issues one toggle and completes.
